// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor.
//
// full_adder            : single-bit full adder cell, purely combinational.
//
// pipelined_rca_addsub  : DATA_WIDTH-bit add/subtract split into NUM_SEG
//                         segments of SEG_WIDTH full_adder cells. Each segment
//                         sits in its own pipeline stage. Operands skew forward
//                         and partial results de-skew with the data. Both sides
//                         use a valid/ready handshake.
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  block accepts this cycle (combinational from out_ready)
//   a, b       in   DATA_WIDTH operands
//   sub        in   0: a+b, 1: a-b (a + ~b + 1)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   sum        out  DATA_WIDTH+1 result, MSB is the final carry-out
//   cout_int   out  per-bit full-adder carry-outs of this result
//   overflow   out  signed overflow (carry into MSB ^ carry out of MSB)

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_c_o,
    output logic cout_c_o
);

    assign sum_c_o  = a_i ^ b_i ^ cin_i;
    assign cout_c_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

module pipelined_rca_addsub #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   sum,
    output logic [DATA_WIDTH-1:0] cout_int,
    output logic                  overflow
);

    localparam int unsigned NUM_SEG = DATA_WIDTH / SEG_WIDTH;
    localparam int unsigned LAST    = NUM_SEG - 1;

    // Reject configurations that cannot be split into whole segments.
    if (SEG_WIDTH == 0 || (DATA_WIDTH % SEG_WIDTH) != 0) begin : g_cfg_err
        $error("pipelined_rca_addsub: DATA_WIDTH must be a multiple of SEG_WIDTH");
    end

    // b is inverted once at the input; the inverted copy travels down the pipe,
    // so later stages need no knowledge of sub beyond the stage-0 carry-in.
    logic [DATA_WIDTH-1:0] b_x_w;
    assign b_x_w = b ^ {DATA_WIDTH{sub}};

    // Combinational results of every segment's ripple chain.
    logic [DATA_WIDTH-1:0] fa_sum_w;
    logic [DATA_WIDTH-1:0] fa_cout_w;
    logic [NUM_SEG-1:0]    seg_carry_w;
    logic                  msb_ovf_w;

    // Per-stage state.
    logic [NUM_SEG-1:0]    vld_q,   vld_d;
    logic [NUM_SEG-1:0]    carry_q, carry_d;
    logic [NUM_SEG-1:0]    adv;
    logic [DATA_WIDTH-1:0] a_q   [NUM_SEG];
    logic [DATA_WIDTH-1:0] a_d   [NUM_SEG];
    logic [DATA_WIDTH-1:0] bx_q  [NUM_SEG];
    logic [DATA_WIDTH-1:0] bx_d  [NUM_SEG];
    logic [DATA_WIDTH-1:0] res_q [NUM_SEG];
    logic [DATA_WIDTH-1:0] res_d [NUM_SEG];
    logic [DATA_WIDTH-1:0] co_q  [NUM_SEG];
    logic [DATA_WIDTH-1:0] co_d  [NUM_SEG];
    logic                  ovf_q, ovf_d;

    // Segment ripple chains: segment 0 from the raw inputs, segment s from the
    // operands and carry registered by stage s-1.
    for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
        logic [SEG_WIDTH-1:0] a_w;
        logic [SEG_WIDTH-1:0] b_w;
        logic [SEG_WIDTH:0]   c_w;

        if (s == 0) begin : g_head
            assign a_w    = a[SEG_WIDTH-1:0];
            assign b_w    = b_x_w[SEG_WIDTH-1:0];
            assign c_w[0] = sub;
        end else begin : g_body
            assign a_w    = a_q[s-1][s*SEG_WIDTH +: SEG_WIDTH];
            assign b_w    = bx_q[s-1][s*SEG_WIDTH +: SEG_WIDTH];
            assign c_w[0] = carry_q[s-1];
        end

        for (genvar i = 0; i < SEG_WIDTH; i++) begin : g_bit
            full_adder u_fa (
                .a_i      (a_w[i]),
                .b_i      (b_w[i]),
                .cin_i    (c_w[i]),
                .sum_c_o  (fa_sum_w[s*SEG_WIDTH + i]),
                .cout_c_o (c_w[i+1])
            );
        end

        assign fa_cout_w[s*SEG_WIDTH +: SEG_WIDTH] = c_w[SEG_WIDTH:1];
        assign seg_carry_w[s]                      = c_w[SEG_WIDTH];

        // The last segment holds the MSB; c_w[SEG_WIDTH-1] is the carry into it
        // (the raw carry-in when the whole word is a single bit).
        if (s == LAST) begin : g_tail
            assign msb_ovf_w = c_w[SEG_WIDTH] ^ c_w[SEG_WIDTH-1];
        end
    end

    // Elastic advance: a stage moves when empty or when its successor moves.
    always_comb begin
        adv       = '0;
        adv[LAST] = !vld_q[LAST] || out_ready;
        for (int k = 1; k < NUM_SEG; k++) begin
            adv[LAST-k] = !vld_q[LAST-k] || adv[LAST-k+1];
        end
    end

    assign in_ready = adv[0];

    // Next-state for every stage; stalled stages hold their contents.
    always_comb begin
        vld_d   = vld_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        for (int s = 0; s < NUM_SEG; s++) begin
            a_d[s]   = a_q[s];
            bx_d[s]  = bx_q[s];
            res_d[s] = res_q[s];
            co_d[s]  = co_q[s];
        end

        if (adv[0]) begin
            vld_d[0]   = in_valid;
            a_d[0]     = a;
            bx_d[0]    = b_x_w;
            res_d[0]   = fa_sum_w;
            co_d[0]    = fa_cout_w;
            carry_d[0] = seg_carry_w[0];
        end

        // Lower segments come from the previous stage, segment s is fresh.
        for (int s = 1; s < NUM_SEG; s++) begin
            if (adv[s]) begin
                vld_d[s]   = vld_q[s-1];
                a_d[s]     = a_q[s-1];
                bx_d[s]    = bx_q[s-1];
                res_d[s]   = res_q[s-1];
                co_d[s]    = co_q[s-1];
                carry_d[s] = seg_carry_w[s];
                res_d[s][s*SEG_WIDTH +: SEG_WIDTH] = fa_sum_w[s*SEG_WIDTH +: SEG_WIDTH];
                co_d[s][s*SEG_WIDTH +: SEG_WIDTH]  = fa_cout_w[s*SEG_WIDTH +: SEG_WIDTH];
            end
        end

        if (adv[LAST]) begin
            ovf_d = msb_ovf_w;
        end
    end

    // Stage registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < NUM_SEG; s++) begin
                a_q[s]   <= '0;
                bx_q[s]  <= '0;
                res_q[s] <= '0;
                co_q[s]  <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int s = 0; s < NUM_SEG; s++) begin
                a_q[s]   <= a_d[s];
                bx_q[s]  <= bx_d[s];
                res_q[s] <= res_d[s];
                co_q[s]  <= co_d[s];
            end
        end
    end

    // Outputs come straight from the last stage register.
    assign out_valid = vld_q[LAST];
    assign sum       = {carry_q[LAST], res_q[LAST]};
    assign cout_int  = co_q[LAST];
    assign overflow  = ovf_q;

endmodule

// File: doc/pipelined_rca_addsub.md
Name: pipelined_rca_addsub

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry adder.
- Splits a DATA_WIDTH add/subtract into NUM_SEG segments of SEG_WIDTH bits, each built from cascaded single-bit full_adder instances.
- Registers the segment carry between pipeline stages, with operand skew and result de-skew, behind a valid/ready handshake on both sides.
- Sits between operand producers and consumers that need full throughput at a clock rate a full-width ripple chain cannot meet.

Parameters:
- DATA_WIDTH, 8: operand width in bits.
- SEG_WIDTH, 4: bits rippled per pipeline stage. DATA_WIDTH % SEG_WIDTH != 0 is an elaboration error.
- NUM_SEG, DATA_WIDTH/SEG_WIDTH: derived local parameter. It equals the pipeline depth and the latency in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept this cycle.
- a  in  DATA_WIDTH  first operand.
- b  in  DATA_WIDTH  second operand.
- sub  in  1  0 = a+b, 1 = a-b (a + ~b + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  DATA_WIDTH+1  result; MSB is the final carry-out.
- cout_int  out  DATA_WIDTH  per-bit full-adder carry-outs for this result.
- overflow  out  1  signed overflow: cout_int[DATA_WIDTH-1] ^ cout_int[DATA_WIDTH-2] (for DATA_WIDTH=1: cout_int[0] ^ carry-in).

Behaviour:
- Reset: out_valid=0, all stage valid bits=0, sum=0, cout_int=0, overflow=0. in_ready reads 1 once reset is removed.
  - Reset is asynchronous: in-flight operations are discarded and never emitted.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready. Output transfer is on out_valid && out_ready.
- Arithmetic:
  - Carry-in to bit 0 is sub. The b input to the full adders is b ^ {DATA_WIDTH{sub}}.
  - sum[DATA_WIDTH] = raw carry-out of bit DATA_WIDTH-1; for subtract, 1 = no borrow. No saturation; results wrap.
- Pipeline:
  - Stage 0: segment 0 ripples combinationally from the input operands and is captured into stage-0 registers with its carry.
  - Stage s (1..NUM_SEG-1): segment s ripples from registered operand bits plus the registered carry of stage s-1.
  - Operand bits of not-yet-computed segments and the sum/cout_int bits of already-computed segments travel with the data (skew/de-skew), together with sub.
  - The last stage register drives sum, cout_int, overflow and out_valid directly. The outputs are registered with no combinational path from inputs.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+NUM_SEG-1, i.e. NUM_SEG stage registers.
- Throughput: one operation per cycle when out_ready=1.
- Flow control (elastic, no bubbles required):
  - A stage advances when it is empty or the next stage advances.
  - The last stage advances when out_ready=1 or it is empty.
  - in_ready = !valid[0] || advance[0]. This is combinational from out_ready through the stage valids; it is permitted.
- Stall:
  - While out_valid && !out_ready, sum/cout_int/overflow are held bit-stable.
  - Upstream stages fill; capacity is NUM_SEG operations. in_ready drops only when all stages are valid and out_ready=0.
- Simultaneous accept and emit with a full pipeline and out_ready=1: both occur on the same edge, with no loss or duplication.
- Order is strictly FIFO.
- Data registers of empty stages may hold stale values. Only valid-qualified outputs are meaningful; the bench must not check sum when out_valid=0 except after reset.
- NUM_SEG=1 (SEG_WIDTH=DATA_WIDTH): single registered stage, latency 1.
- Every segment must be built from full_adder instances (SEG_WIDTH per segment, DATA_WIDTH total). No behavioural '+' on operands.

Test Plan (DATA_WIDTH=8, SEG_WIDTH=4, latency 2):
- Reset: assert reset mid-cycle with idle inputs -> out_valid=0, sum=9'h000, cout_int=8'h00, overflow=0 immediately; in_ready=1 after release.
- Add carry ripple across segments: a=8'hFF, b=8'h01, sub=0, out_ready=1 -> 2 cycles later out_valid=1, sum=9'h100, cout_int=8'hFF, overflow=0.
- Subtract with borrow: a=8'h05, b=8'h07, sub=1 -> sum=9'h0FE, cout_int=8'h01, overflow=0. Signed overflow: a=8'h7F, b=8'h01, sub=0 -> sum=9'h080, overflow=1.
- Streaming: four back-to-back ops (FF+01, 05-07, 7F+01, 80-01) with in_valid=1, out_ready=1 -> four consecutive out_valid cycles, in order.
  - Expected: 9'h100, 9'h0FE, 9'h080 (ovf=1), 9'h17F (ovf=1).
- Backpressure: out_ready=0, present three ops -> first two accepted, in_ready=0 on third; output held stable for 5 cycles.
  - Then out_ready=1 -> all three emitted in order, one per cycle, none lost or duplicated.
- Reset mid-stream: two ops in flight, pulse reset between edges -> out_valid drops asynchronously; neither op ever emitted; next op after release returns correct result with latency 2.
